// File: rtl/bridge_download_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// bridge_download_unpacker_pkg
//   Types and constants shared by the download unpacker and its FIFO.
//   - out_state_t : output-stage states (IDLE / LO halfword / HI halfword)
//   - REGION_MSB/LSB : bridge address bits that select the download window
//   - entry_w()   : width of one FIFO entry ({word address, 32-bit data})
// -----------------------------------------------------------------------------
package bridge_download_unpacker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } out_state_t;

  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 28;

  // A FIFO entry holds the word address (byte address without bits [1:0])
  // followed by the full 32-bit data word.
  function automatic int entry_w(input int addr_width);
    return addr_width - 2 + 32;
  endfunction

endpackage

// File: rtl/bridge_download_unpacker_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered read data.
//   Ports:
//     clk, reset_n : clock, synchronous active-low reset
//     push, din    : write request / data (ignored when full)
//     pop          : read request (ignored when empty)
//     dout         : read data, valid the cycle after the pop edge; it holds
//                    its value until the next effective pop
//     full, empty  : status, reflecting the state before the next edge
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells a full FIFO from an empty one.
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] dout_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_q;

  // NOTE: the storage array has no reset; the pointers alone define what is
  // valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[PW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        dout_q   <= mem[rd_ptr_q[PW-1:0]];
        rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/bridge_download_unpacker.sv
// -----------------------------------------------------------------------------
// bridge_download_unpacker
//   Captures 32-bit APF bridge writes that fall in the download window,
//   buffers them, and replays each as two 16-bit words (low half first) on a
//   valid/ready stream toward the SDRAM writer.
//   Ports:
//     clk, reset_n      : bridge clock, synchronous active-low reset
//     bridge_wr         : write strobe, one cycle per word
//     bridge_addr       : byte address; [31:28] selects the window
//     bridge_wr_data    : little-endian write data
//     bridge_done       : host says all data slots are complete (level)
//     dl_valid/dl_ready : output handshake
//     dl_addr, dl_data  : halfword byte address and data
//     dl_done           : bridge_done seen and everything drained
//     overflow          : sticky, a write was dropped on a full FIFO
// -----------------------------------------------------------------------------
module bridge_download_unpacker
  import bridge_download_unpacker_pkg::*;
#(
  parameter int          ADDR_WIDTH = 26,
  parameter int          DEPTH      = 16,
  parameter logic [3:0]  REGION     = 4'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bridge_wr,
  input  logic [31:0]           bridge_addr,
  input  logic [31:0]           bridge_wr_data,
  input  logic                  bridge_done,
  output logic                  dl_valid,
  input  logic                  dl_ready,
  output logic [ADDR_WIDTH-1:0] dl_addr,
  output logic [15:0]           dl_data,
  output logic                  dl_done,
  output logic                  overflow
);

  localparam int ENTRY_W = entry_w(ADDR_WIDTH);

  out_state_t         state_q;
  logic               valid_q;
  logic               done_q;
  logic               overflow_q;

  logic               accept;
  logic               handshake;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic [ADDR_WIDTH-3:0] entry_addr;
  logic               unused_addr;

  // Only the window-select and word-address bits matter; the rest of the
  // bridge address is intentionally dropped.
  assign unused_addr = ^bridge_addr;

  assign accept    = bridge_wr && (bridge_addr[REGION_MSB:REGION_LSB] == REGION);
  assign fifo_din  = {bridge_addr[ADDR_WIDTH-1:2], bridge_wr_data};
  // Full is judged before this edge, so a pop in the same cycle cannot rescue
  // a write that arrives while full.
  assign fifo_push = accept && !fifo_full;
  assign handshake = valid_q && dl_ready;
  // The FIFO read is registered: popping on the edge that enters LO makes the
  // entry appear on fifo_dout exactly when LO starts, with no bubble.
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == HI) && handshake));

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (accept && fifo_full) begin
        overflow_q <= 1'b1;
      end
      done_q <= bridge_done && fifo_empty && (state_q == IDLE) && !accept;

      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= LO;
            valid_q <= 1'b1;
          end
        end
        LO: begin
          if (handshake) begin
            state_q <= HI;
          end
        end
        HI: begin
          if (handshake) begin
            if (!fifo_empty) begin
              state_q <= LO;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Data and address come straight from the FIFO's read register, which only
  // moves on a pop, so they stay stable for as long as the consumer stalls.
  assign entry_addr = fifo_dout[ENTRY_W-1:32];
  assign dl_valid   = valid_q;
  assign dl_data    = !valid_q          ? 16'h0000 :
                      (state_q == HI)   ? fifo_dout[31:16] : fifo_dout[15:0];
  assign dl_addr    = !valid_q ? '0 : {entry_addr, (state_q == HI), 1'b0};
  assign dl_done    = done_q;
  assign overflow   = overflow_q;

endmodule
